// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: descriptor stream carrying symbolic instructions into the loader.
interface instr_mem_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  modport master (
    output in_valid, in_last, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
    input  in_ready
  );
  modport slave (
    input  in_valid, in_last, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
    output in_ready
  );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: encodes descriptors into MIPS words and writes them to consecutive addresses.
module instr_mem_loader #(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  instr_mem_loader_if.slave    desc,
  output logic                 im_we,
  output logic [AW-1:0]        im_addr,
  output logic [31:0]          im_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 full,
  output logic                 err,
  output logic [AW:0]          count
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  localparam logic [AW:0] maxCount = (AW+1)'(DEPTH);
  state_t        state;
  logic [AW-1:0] wptr;
  logic          inReady;
  logic          accept;
  logic          legal;
  logic [5:0]    op6;
  logic [31:0]   word;
  assign desc.in_ready = inReady;
  assign accept = inReady & desc.in_valid;
  assign busy = state != IDLE;
  always_comb begin
    op6 = 6'b000000;
    legal = 1'b1;
    case (desc.in_op)
      4'd0, 4'd6: op6 = 6'b000000;
      4'd1:       op6 = 6'b001000;
      4'd2:       op6 = 6'b001010;
      4'd3:       op6 = 6'b001100;
      4'd4:       op6 = 6'b001101;
      4'd5:       op6 = 6'b001110;
      4'd7:       op6 = 6'b000100;
      4'd8:       op6 = 6'b000101;
      4'd9:       op6 = 6'b100011;
      4'd10:      op6 = 6'b101011;
      default:    legal = 1'b0;
    endcase
    word = desc.in_op == 4'd0 ? {6'b000000, desc.in_rs, desc.in_rt, desc.in_rd, 5'b00000, desc.in_funct} :
           desc.in_op == 4'd6 ? {6'b000010, desc.in_target} :
                                {op6, desc.in_rs, desc.in_rt, desc.in_imm};
  end
  // Writes are registered straight out of the accept edge, so the strobe lands one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wptr     <= '0;
      inReady  <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      done     <= 1'b0;
      full     <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
    end else begin
      im_we <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= LOAD;
          wptr    <= base_addr;
          count   <= '0;
          err     <= 1'b0;
          full    <= 1'b0;
          inReady <= 1'b1;
        end
        LOAD: if (accept) begin
          if (legal) begin
            im_we    <= 1'b1;
            im_addr  <= wptr;
            im_wdata <= word;
            wptr     <= wptr + AW'(1);
            count    <= count + (AW+1)'(1);
          end else begin
            err <= 1'b1;
          end
          if (desc.in_last || (legal && count + (AW+1)'(1) == maxCount)) begin
            state   <= DRAIN;
            inReady <= 1'b0;
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
          full  <= count == maxCount;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed scenario checks of the instruction loader with DEPTH=4.
module tb_instr_mem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        im_we, busy, done, full, err;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic [8:0]  count;
  int tests = 0;
  int fails = 0;
  int doneCnt = 0;
  logic [39:0] wq[$];
  instr_mem_loader_if bus();
  instr_mem_loader #(.AW(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .desc(bus.slave),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy), .done(done),
    .full(full), .err(err), .count(count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #2;
    if (im_we) wq.push_back({im_addr, im_wdata});
    if (done) doneCnt++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic beat(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [5:0] f, input logic [15:0] imm, input logic [25:0] tg, input logic last);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_funct = f; bus.in_imm = imm; bus.in_target = tg; bus.in_last = last;
    for (int i = 0; i < 10 && bus.in_ready !== 1'b1; i++) @(negedge clk);
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL beat_ready got %b want 1", bus.in_ready); end
    @(negedge clk);
  endtask

  task automatic startS(input logic [7:0] b);
    start = 1'b1; base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL wait_done got %b want 1", done); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if ({im_we, busy, done, full, err, bus.in_ready} !== 6'b0) begin fails++; $display("FAIL reset_flags got %b want 000000", {im_we, busy, done, full, err, bus.in_ready}); end
    tests++; if ({im_addr, im_wdata, count} !== 49'b0) begin fails++; $display("FAIL reset_data got %h want 0", {im_addr, im_wdata, count}); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_idle busy %b ready %b want 0 0", busy, bus.in_ready); end
  endtask

  task automatic test_single();
    wq.delete();
    startS(8'h10);
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL single_ready got %b want 1", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_op = 4'd1; bus.in_rs = 5'd1; bus.in_rt = 5'd2; bus.in_imm = 16'h0005; bus.in_last = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++; if (im_we !== 1'b1) begin fails++; $display("FAIL single_we got %b want 1", im_we); end
    tests++; if (im_addr !== 8'h10) begin fails++; $display("FAIL single_addr got %h want 10", im_addr); end
    tests++; if (im_wdata !== 32'h20220005) begin fails++; $display("FAIL single_data got %h want 20220005", im_wdata); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL single_drop got %b want 0", bus.in_ready); end
    @(negedge clk);
    tests++; if (done !== 1'b1 || im_we !== 1'b0) begin fails++; $display("FAIL single_done done %b we %b want 1 0", done, im_we); end
    @(negedge clk);
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_end done %b busy %b want 0 0", done, busy); end
    tests++; if (count !== 9'd1 || err !== 1'b0) begin fails++; $display("FAIL single_count count %0d err %b want 1 0", count, err); end
  endtask

  task automatic test_mixed();
    logic [39:0] exp [3] = '{{8'h00, 32'h00642820}, {8'h01, 32'h08000040}, {8'h02, 32'hAFBFFFFC}};
    logic [39:0] got;
    wq.delete();
    startS(8'h00);
    beat(4'd0, 5'd3, 5'd4, 5'd5, 6'h20, 16'h0, 26'h0, 1'b0);
    beat(4'd6, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h40, 1'b0);
    beat(4'd10, 5'd29, 5'd31, 5'd0, 6'h0, 16'hFFFC, 26'h0, 1'b1);
    bus.in_valid = 1'b0;
    waitDone();
    tests++; if (wq.size() !== 3) begin fails++; $display("FAIL mixed_size got %0d want 3", wq.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < wq.size()) ? wq[i] : '1;
      tests++; if (got !== exp[i]) begin fails++; $display("FAIL mixed_word%0d got %h want %h", i, got, exp[i]); end
    end
    tests++; if (count !== 9'd3) begin fails++; $display("FAIL mixed_count got %0d want 3", count); end
  endtask

  task automatic test_illegal();
    logic [39:0] exp [2] = '{{8'h20, 32'h342200FF}, {8'h21, 32'h8C640008}};
    logic [39:0] got;
    wq.delete();
    startS(8'h20);
    beat(4'd4, 5'd1, 5'd2, 5'd0, 6'h0, 16'h00FF, 26'h0, 1'b0);
    beat(4'd12, 5'd7, 5'd7, 5'd7, 6'h3F, 16'h1234, 26'h0, 1'b0);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL illegal_err_now got %b want 1", err); end
    beat(4'd9, 5'd3, 5'd4, 5'd0, 6'h0, 16'h0008, 26'h0, 1'b1);
    bus.in_valid = 1'b0;
    waitDone();
    repeat (2) @(negedge clk);
    tests++; if (wq.size() !== 2) begin fails++; $display("FAIL illegal_size got %0d want 2", wq.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < wq.size()) ? wq[i] : '1;
      tests++; if (got !== exp[i]) begin fails++; $display("FAIL illegal_word%0d got %h want %h", i, got, exp[i]); end
    end
    tests++; if (err !== 1'b1 || count !== 9'd2) begin fails++; $display("FAIL illegal_sticky err %b count %0d want 1 2", err, count); end
  endtask

  task automatic test_capacity();
    int d0;
    logic [39:0] got;
    wq.delete();
    d0 = doneCnt;
    startS(8'h40);
    for (int i = 0; i < 4; i++) beat(4'd1, 5'd1, 5'd2, 5'd0, 6'h0, 16'(i), 26'h0, 1'b0);
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL cap_ready got %b want 0", bus.in_ready); end
    bus.in_imm = 16'd4;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    tests++; if (doneCnt - d0 !== 1) begin fails++; $display("FAIL cap_done got %0d want 1", doneCnt - d0); end
    tests++; if (wq.size() !== 4) begin fails++; $display("FAIL cap_size got %0d want 4", wq.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < wq.size()) ? wq[i] : '1;
      tests++; if (got !== {8'h40 + 8'(i), 32'h20220000 + 32'(i)}) begin fails++; $display("FAIL cap_word%0d got %h want %h", i, got, {8'h40 + 8'(i), 32'h20220000 + 32'(i)}); end
    end
    tests++; if (full !== 1'b1 || count !== 9'd4 || busy !== 1'b0) begin fails++; $display("FAIL cap_full full %b count %0d busy %b want 1 4 0", full, count, busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] expA [3] = '{8'hFE, 8'hFF, 8'h00};
    logic [39:0] got;
    wq.delete();
    startS(8'hFE);
    tests++; if (err !== 1'b0 || full !== 1'b0 || count !== 9'd0) begin fails++; $display("FAIL wrap_clear err %b full %b count %0d want 0 0 0", err, full, count); end
    beat(4'd1, 5'd1, 5'd2, 5'd0, 6'h0, 16'd1, 26'h0, 1'b0);
    beat(4'd1, 5'd1, 5'd2, 5'd0, 6'h0, 16'd2, 26'h0, 1'b0);
    beat(4'd1, 5'd1, 5'd2, 5'd0, 6'h0, 16'd3, 26'h0, 1'b1);
    bus.in_valid = 1'b0;
    waitDone();
    tests++; if (wq.size() !== 3) begin fails++; $display("FAIL wrap_size got %0d want 3", wq.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < wq.size()) ? wq[i] : '1;
      tests++; if (got !== {expA[i], 32'h20220001 + 32'(i)}) begin fails++; $display("FAIL wrap_word%0d got %h want %h", i, got, {expA[i], 32'h20220001 + 32'(i)}); end
    end
  endtask

  task automatic test_robust();
    logic [39:0] got;
    wq.delete();
    bus.in_valid = 1'b1; bus.in_op = 4'd1; bus.in_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL idle_ready got %b want 0", bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    tests++; if (wq.size() !== 0 || busy !== 1'b0) begin fails++; $display("FAIL idle_writes got %0d busy %b want 0 0", wq.size(), busy); end
    startS(8'h80);
    beat(4'd1, 5'd1, 5'd2, 5'd0, 6'h0, 16'd7, 26'h0, 1'b0);
    bus.in_valid = 1'b0;
    startS(8'h90);
    beat(4'd1, 5'd1, 5'd2, 5'd0, 6'h0, 16'd8, 26'h0, 1'b1);
    bus.in_valid = 1'b0;
    waitDone();
    tests++; if (wq.size() !== 2) begin fails++; $display("FAIL restart_size got %0d want 2", wq.size()); end
    got = (wq.size() > 1) ? wq[1] : '1;
    tests++; if (got !== {8'h81, 32'h20220008}) begin fails++; $display("FAIL restart_word got %h want 8120220008", got); end
    wq.delete();
    startS(8'h50);
    bus.in_valid = 1'b1; bus.in_imm = 16'd9; bus.in_last = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++; if ({im_we, busy, done, full, err, bus.in_ready} !== 6'b0) begin fails++; $display("FAIL midrst_flags got %b want 000000", {im_we, busy, done, full, err, bus.in_ready}); end
    tests++; if ({im_addr, im_wdata, count} !== 49'b0) begin fails++; $display("FAIL midrst_data got %h want 0", {im_addr, im_wdata, count}); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (wq.size() !== 0 || busy !== 1'b0) begin fails++; $display("FAIL midrst_writes got %0d busy %b want 0 0", wq.size(), busy); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0;
    bus.in_rd = '0; bus.in_funct = '0; bus.in_imm = '0; bus.in_target = '0;
    test_reset();
    test_single();
    test_mixed();
    test_illegal();
    test_capacity();
    test_wrap();
    test_robust();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
